div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencer between the EX stage and the iterative divider. It detects DIV/DIVU in EX, registers operands and signedness, and drives the divider's start/annul handshake. It holds the pipeline via a stall request until the result arrives, then presents HI/LO with a write-enable for exactly one advancing cycle. On pipeline flush it annuls the operation and drains the divider before accepting a new divide.

## Interface
- No parameters. Opcodes, state codes and widths come from `defines.v`.
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `aluop_i` in 8: EX-stage ALU op. A divide is `EXE_DIV_OP` (signed) or `EXE_DIVU_OP` (unsigned).
- `reg1_i`, `reg2_i` in 32: dividend and divisor from EX.
- `flush_i` in 1: pipeline flush (exception); kills the EX instruction.
- `hold_i` in 1: EX/MEM register not advancing this cycle (stall from a later stage).
- `div_opdata1_o`, `div_opdata2_o` out 32: registered operands to the divider.
- `signed_div_o` out 1: registered, 1 for DIV.
- `div_start_o` out 1: registered start level.
- `div_annul_o` out 1: registered cancel.
- `div_result_i` in 64: `{remainder, quotient}`.
- `div_ready_i` in 1: divider result valid (level, held until start drops).
- `stallreq_o` out 1: combinational stall request to the pipeline controller.
- `hi_o`, `lo_o` out 32: remainder and quotient.
- `whilo_o` out 1: HI/LO write enable.

## Operation
- Define `is_div` = (`aluop_i` is DIV or DIVU).
- FSM states are IDLE, BUSY, RESULT and DRAIN, 2-bit encoding in `defines.v`. A 2-bit drain counter is used in DRAIN.
- Reset: state IDLE. All registered outputs (`div_opdata*`, `signed_div_o`, `div_start_o`, `div_annul_o`, `hi_o`, `lo_o`) are 0.
- IDLE:
  - `is_div` && !`flush_i`: `stallreq_o`=1. Latch `reg1_i`, `reg2_i` and signedness, set `div_start_o`=1, go to BUSY.
  - Otherwise stay; `stallreq_o`=0.
- BUSY: `stallreq_o`=1 and `div_start_o` held at 1.
  - `flush_i`=1 (highest priority): `stallreq_o`=0, `div_start_o`<=0, `div_annul_o`<=1, counter<=2, go to DRAIN. Any concurrent `div_ready_i` is discarded.
  - `div_ready_i`=1: `hi_o`<=`div_result_i[63:32]`, `lo_o`<=`div_result_i[31:0]`, `div_start_o`<=0, go to RESULT.
- RESULT: `stallreq_o`=0 and `whilo_o` = !`flush_i`. HI/LO stay stable.
  - Leave to IDLE when `hold_i`=0 or `flush_i`=1; otherwise stay.
  - `div_ready_i` is ignored in this state (the divider may still show 1 for one cycle).
- DRAIN: `div_annul_o`=1, `div_start_o`=0, and the counter decrements each cycle. Go to IDLE when it reaches 0. `stallreq_o` = `is_div` && !`flush_i`. `flush_i` has no further effect.
- `whilo_o` is 0 in every state except RESULT.
- Divide by zero needs no special case. The divider returns `{0,0}`, which is passed through.

## Timing
Cycle 0 is the first cycle a divide is in EX while the controller is IDLE.
- Edge 0 registers start. The divider samples it at edge 1, iterates on edges 2–33, sign-fixes at edge 34, and raises ready at edge 35.
- BUSY sees `div_ready_i` in cycle 36. RESULT is cycle 37.
- `stallreq_o`=1 in cycles 0–36 (37 cycles). The instruction leaves EX at edge 37 if `hold_i`=0.
- Divisor 0: ready is visible in cycle 4, RESULT is cycle 5, `stallreq_o`=1 in cycles 0–4.
- Back-to-back divides:
  - After RESULT, the earliest re-entry is IDLE the next cycle. The divider has already seen start=0 for at least one edge, so it is free.
  - A divide arriving in DRAIN stalls until IDLE.
- Flush in BUSY during cycle c: `div_annul_o`=1 in cycles c+1 and c+2, IDLE at c+3.
  - This covers the worst case, a flush in cycle 1 with divisor 0: ZeroDiv, End, Free.
- Reset asserted mid-operation returns to IDLE immediately. The parent must reset the divider with the same `rst`.

## Structure
- `defines.v` holds the FSM state codes (`DivCtrlIdle`, `DivCtrlBusy`, `DivCtrlResult`, `DivCtrlDrain`) and reuses `EXE_DIV_OP`, `EXE_DIVU_OP`, `DivStart`, `DivStop`, `DivResultReady`, `ZeroWord` and `AluOpBus`.
- There is no sub-module. The divider is instantiated beside `div_ctrl` by the EX-stage parent. `stallreq_o` is ORed into the pipeline `ctrl` stall logic.

## Test plan
- DIVU 100/7 → `stallreq_o` high for 37 cycles; cycle 37 gives `whilo_o`=1, `hi_o`=2, `lo_o`=14 for one cycle only.
- DIV 0xFFFFFFF9/2 (−7/2) → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF, `signed_div_o`=1. DIVU with the same operands → `lo_o`=0x7FFFFFFC, `hi_o`=1.
- DIV 5/0 → 5 stall cycles; RESULT in cycle 5 with `hi_o`=`lo_o`=0.
- Flush in cycle 10 → `div_annul_o` high cycles 11–12, no `whilo_o`. A following DIVU 9/3 → `lo_o`=3, `hi_o`=0, with normal 37-cycle latency.
- `hold_i`=1 for 3 cycles in RESULT → `whilo_o`, `hi_o`, `lo_o` stable for 4 cycles. A back-to-back second divide then completes correctly.
- Flush in cycle 1 with divisor 0, then an immediate new divide → second start not issued before cycle 4, result correct. Async `rst` in cycle 20 → `stallreq_o` and all outputs 0 with no clock edge.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared opcodes, handshake levels and FSM state codes for the divide sequencer.
package div_ctrl_pkg;

  localparam int ALU_OP_W = 8;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t     EXE_DIV_OP     = 8'b0001_1010;
  localparam alu_op_t     EXE_DIVU_OP    = 8'b0001_1011;
  localparam logic        DivStart       = 1'b1;
  localparam logic        DivStop        = 1'b0;
  localparam logic        DivResultReady = 1'b1;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;

  typedef enum logic [1:0] {
    DivCtrlIdle   = 2'b00,
    DivCtrlBusy   = 2'b01,
    DivCtrlResult = 2'b10,
    DivCtrlDrain  = 2'b11
  } div_ctrl_state_e;

  function automatic logic is_div_op(alu_op_t op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// EX-stage divide sequencer: launches the iterative divider, stalls the pipe
// until the result lands, then presents HI/LO for one advancing cycle.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  alu_op_t       aluop_i,
  input  logic [31:0]   reg1_i,
  input  logic [31:0]   reg2_i,
  input  logic          flush_i,
  input  logic          hold_i,
  output logic [31:0]   div_opdata1_o,
  output logic [31:0]   div_opdata2_o,
  output logic          signed_div_o,
  output logic          div_start_o,
  output logic          div_annul_o,
  input  logic [63:0]   div_result_i,
  input  logic          div_ready_i,
  output logic          stallreq_o,
  output logic [31:0]   hi_o,
  output logic [31:0]   lo_o,
  output logic          whilo_o
);

  div_ctrl_state_e state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     op1_q, op1_d, op2_q, op2_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            sgn_q, sgn_d;
  logic            start_q, start_d;
  logic            annul_q, annul_d;
  logic            is_div;

  assign is_div = is_div_op(aluop_i);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    sgn_d      = sgn_q;
    start_d    = start_q;
    annul_d    = annul_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    case (state_q)
      DivCtrlIdle: begin
        if (is_div && !flush_i) begin
          stallreq_o = 1'b1;
          op1_d      = reg1_i;
          op2_d      = reg2_i;
          sgn_d      = (aluop_i == EXE_DIV_OP);
          start_d    = DivStart;
          state_d    = DivCtrlBusy;
        end
      end
      DivCtrlBusy: begin
        stallreq_o = 1'b1;
        start_d    = DivStart;
        // Flush wins over a same-cycle ready; that result is thrown away.
        if (flush_i) begin
          stallreq_o = 1'b0;
          start_d    = DivStop;
          annul_d    = 1'b1;
          cnt_d      = 2'd2;
          state_d    = DivCtrlDrain;
        end else if (div_ready_i == DivResultReady) begin
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          start_d = DivStop;
          state_d = DivCtrlResult;
        end
      end
      DivCtrlResult: begin
        whilo_o = !flush_i;
        if (!hold_i || flush_i) state_d = DivCtrlIdle;
      end
      DivCtrlDrain: begin
        // Two annul cycles let the divider reach Free even from ZeroDiv.
        stallreq_o = is_div && !flush_i;
        start_d    = DivStop;
        annul_d    = 1'b1;
        cnt_d      = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          annul_d = 1'b0;
          cnt_d   = 2'd0;
          state_d = DivCtrlIdle;
        end
      end
      default: state_d = DivCtrlIdle;
    endcase
    // The rest of the pipe is in reset too; never request a stall then.
    if (rst) stallreq_o = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DivCtrlIdle;
      cnt_q   <= 2'd0;
      op1_q   <= ZeroWord;
      op2_q   <= ZeroWord;
      sgn_q   <= 1'b0;
      start_q <= DivStop;
      annul_q <= 1'b0;
      hi_q    <= ZeroWord;
      lo_q    <= ZeroWord;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sgn_q   <= sgn_d;
      start_q <= start_d;
      annul_q <= annul_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign signed_div_o  = sgn_q;
  assign div_start_o   = start_q;
  assign div_annul_o   = annul_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a cycle-level model of the iterative divider beside it.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk, rst;
  alu_op_t     aluop_i;
  logic [31:0] reg1_i, reg2_i;
  logic        flush_i, hold_i;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic        signed_div_o, div_start_o, div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o;
  logic [31:0] hi_o, lo_o;
  logic        whilo_o;

  int checks   = 0;
  int failures = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .flush_i(flush_i), .hold_i(hold_i),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .signed_div_o(signed_div_o), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: Free -> ZeroDiv/On -> End; 32 iterations plus a sign-fix edge.
  int          mst, mcnt;
  logic [63:0] mres;

  function automatic logic [63:0] div_calc(logic [31:0] a, logic [31:0] b, logic s);
    logic signed [31:0] sq, sr;
    logic [31:0] uq, ur;
    if (s) begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      return {sr, sq};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mst <= 0; mcnt <= 0; mres <= '0;
      div_ready_i <= 1'b0; div_result_i <= '0;
    end else begin
      case (mst)
        0: begin
          div_ready_i  <= 1'b0;
          div_result_i <= '0;
          if (div_start_o && !div_annul_o) begin
            mcnt <= 0;
            if (div_opdata2_o == 32'd0) mst <= 1;
            else begin
              mst  <= 2;
              mres <= div_calc(div_opdata1_o, div_opdata2_o, signed_div_o);
            end
          end
        end
        1: begin mres <= '0; mst <= 3; end
        2: begin
          if (div_annul_o) mst <= 0;
          else if (mcnt != 32) mcnt <= mcnt + 1;
          else mst <= 3;
        end
        default: begin
          if (div_start_o) begin
            div_ready_i  <= 1'b1;
            div_result_i <= mres;
          end else begin
            mst <= 0; div_ready_i <= 1'b0; div_result_i <= '0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; cycle 0 is the current cycle. Returns at posedge+1
  // just after the edge that moves the instruction out of EX.
  task automatic run_div(input string tag, input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic es, input int est, input int hold_n);
    int n;
    aluop_i = op; reg1_i = a; reg2_i = b;
    @(negedge clk);
    chk({tag, " c0 whilo"}, whilo_o, 0);
    chk({tag, " c0 start"}, div_start_o, 0);
    n = 0;
    while (stallreq_o === 1'b1 && n < 100) begin
      n++;
      if (n == 2) begin
        chk({tag, " start"}, div_start_o, 1);
        chk({tag, " signed"}, signed_div_o, es);
        chk({tag, " opdata1"}, div_opdata1_o, a);
        chk({tag, " opdata2"}, div_opdata2_o, b);
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk({tag, " stall cycles"}, n, est);
    for (int k = 0; k <= hold_n; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, " whilo"}, whilo_o, 1);
      chk({tag, " hi"}, hi_o, ehi);
      chk({tag, " lo"}, lo_o, elo);
      chk({tag, " result stall"}, stallreq_o, 0);
      hold_i = (k < hold_n);
      @(posedge clk); #1;
    end
    hold_i = 1'b0;
    aluop_i = 8'h00;
  endtask

  typedef struct {
    alu_op_t     op;
    logic [31:0] a, b, hi, lo;
    logic        sgn;
    int          stall;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{EXE_DIVU_OP, 32'd100,        32'd7, 32'd2,        32'd14,       1'b0, 37, 0};
    vecs[1] = '{EXE_DIV_OP,  32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 37, 0};
    vecs[2] = '{EXE_DIVU_OP, 32'hFFFF_FFF9,  32'd2, 32'd1,        32'h7FFF_FFFC, 1'b0, 37, 0};
    vecs[3] = '{EXE_DIV_OP,  32'd5,          32'd0, 32'd0,        32'd0,        1'b1, 5,  0};
    vecs[4] = '{EXE_DIVU_OP, 32'd1000,       32'd10, 32'd0,       32'd100,      1'b0, 37, 3};
    vecs[5] = '{EXE_DIV_OP,  32'hFFFF_FF9C,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b1, 37, 0};

    rst = 1'b1; aluop_i = 8'h00; reg1_i = '0; reg2_i = '0; flush_i = 1'b0; hold_i = 1'b0;
    #12;
    chk("rst stall", stallreq_o, 0);
    chk("rst whilo", whilo_o, 0);
    chk("rst start", div_start_o, 0);
    chk("rst annul", div_annul_o, 0);
    chk("rst hilo", {hi_o, lo_o}, 0);
    chk("rst opdata", {div_opdata1_o, div_opdata2_o}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back table vectors, including divide-by-zero and a held RESULT.
    for (int i = 0; i < 6; i++)
      run_div($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi,
              vecs[i].lo, vecs[i].sgn, vecs[i].stall, vecs[i].hold);

    // Flush in cycle 10 of a long divide.
    aluop_i = EXE_DIVU_OP; reg1_i = 32'd100; reg2_i = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush10 stall", stallreq_o, 0);
    chk("flush10 whilo", whilo_o, 0);
    @(posedge clk); #1;
    flush_i = 1'b0; aluop_i = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("flush10 annul c%0d", 11 + i), div_annul_o, (i < 2));
      chk($sformatf("flush10 start c%0d", 11 + i), div_start_o, 0);
      chk($sformatf("flush10 whilo c%0d", 11 + i), whilo_o, 0);
    end
    @(posedge clk); #1;
    run_div("after flush", EXE_DIVU_OP, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 37, 0);

    // Flush in cycle 1 of a divide by zero, new divide waiting in DRAIN.
    aluop_i = EXE_DIV_OP; reg1_i = 32'd5; reg2_i = 32'd0;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; aluop_i = EXE_DIVU_OP; reg1_i = 32'd9; reg2_i = 32'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("drain annul c%0d", 2 + i), div_annul_o, 1);
      chk($sformatf("drain start c%0d", 2 + i), div_start_o, 0);
      chk($sformatf("drain stall c%0d", 2 + i), stallreq_o, 1);
    end
    @(posedge clk); #1;
    run_div("post drain", EXE_DIVU_OP, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 37, 0);

    // Async reset in cycle 20 with a divide still sitting in EX.
    aluop_i = EXE_DIVU_OP; reg1_i = 32'd100; reg2_i = 32'd7;
    repeat (20) begin @(posedge clk); #1; end
    #1; rst = 1'b1; #1;
    chk("arst stall", stallreq_o, 0);
    chk("arst start", div_start_o, 0);
    chk("arst annul", div_annul_o, 0);
    chk("arst signed", signed_div_o, 0);
    chk("arst opdata", {div_opdata1_o, div_opdata2_o}, 0);
    chk("arst hilo", {hi_o, lo_o}, 0);
    chk("arst whilo", whilo_o, 0);
    @(negedge clk); rst = 1'b0; aluop_i = 8'h00;
    @(posedge clk); #1;
    run_div("after rst", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 37, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
